// File: rtl/acc_port_arbiter.sv
// Accelerator port arbiter: routes dispatcher requests to NrAcc ports and
// merges responses/completions. Optional cross-port ordering: ACC_PORT_ARBITER_IN_ORDER_EN.
package acc_port_arbiter_pkg;
  typedef struct packed {
    logic        req_valid;
    logic        resp_ready;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  trans_id;
    logic        store_pending;
  } accelerator_req_t;

  typedef struct packed {
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] result;
    logic [4:0]  trans_id;
    logic        exception;
    logic        load_complete;
    logic        store_complete;
    logic        store_pending;
  } accelerator_resp_t;
endpackage

module acc_port_arbiter
  import acc_port_arbiter_pkg::*;
#(
  parameter int unsigned NrAcc    = 2,
  parameter int unsigned MaxOutst = 8,
  parameter int unsigned MaxCompl = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  accelerator_req_t  disp_req_i,
  output accelerator_resp_t disp_resp_o,
  output accelerator_req_t  acc_req_o  [NrAcc],
  input  accelerator_resp_t acc_resp_i [NrAcc],
  output logic              busy_o
);

  localparam int unsigned IdxW = (NrAcc > 1) ? $clog2(NrAcc) : 1;
  localparam int unsigned OW   = $clog2(MaxOutst + 1);
  localparam int unsigned CW   = $clog2(MaxCompl + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q;
  accelerator_req_t req_q;
  idx_t             tgt_q;
  idx_t             rr_q;
  logic [OW-1:0]    outst_q [NrAcc];
  logic [CW-1:0]    lcnt_q  [NrAcc];
  logic [CW-1:0]    scnt_q  [NrAcc];
`ifdef ACC_PORT_ARBITER_IN_ORDER_EN
  idx_t             last_tgt_q;
`endif

  logic             fwd_en, req_hs, resp_hs, gnt_valid, ld_found, st_found;
  idx_t             grant, cand;
  logic [NrAcc-1:0] out_inc, out_dec, ld_dr, st_dr;

  function automatic idx_t decode_tgt(input logic [6:0] op);
    idx_t t;
    t = '0;
    case (op)
      7'b0001011: t = idx_t'(32'd1 % NrAcc);
      7'b0101011: t = idx_t'(32'd2 % NrAcc);
      7'b1011011: t = idx_t'(32'd3 % NrAcc);
      7'b1111011: t = idx_t'(32'd4 % NrAcc);
      default:    t = '0;
    endcase
    return t;
  endfunction

  // A buffered request is offered only while the target has credit and,
  // in ordered mode, the previously used port has fully drained.
  always_comb begin
    fwd_en = (state_q == FULL) && (outst_q[tgt_q] != OW'(MaxOutst));
`ifdef ACC_PORT_ARBITER_IN_ORDER_EN
    if ((tgt_q != last_tgt_q) && (outst_q[last_tgt_q] != '0)) fwd_en = 1'b0;
`endif
    req_hs = fwd_en && acc_resp_i[tgt_q].req_ready;
  end

  always_comb begin
    gnt_valid = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NrAcc; k++) begin
      cand = idx_t'((32'(rr_q) + k) % NrAcc);
      if (!gnt_valid && acc_resp_i[cand].resp_valid) begin
        grant     = cand;
        gnt_valid = 1'b1;
      end
    end
    resp_hs = gnt_valid && disp_req_i.resp_ready;
  end

  always_comb begin
    ld_dr    = '0;
    st_dr    = '0;
    ld_found = 1'b0;
    st_found = 1'b0;
    out_inc  = '0;
    out_dec  = '0;
    for (int unsigned p = 0; p < NrAcc; p++) begin
      if (!ld_found && lcnt_q[p] != '0) begin
        ld_dr[p] = 1'b1;
        ld_found = 1'b1;
      end
      if (!st_found && scnt_q[p] != '0) begin
        st_dr[p] = 1'b1;
        st_found = 1'b1;
      end
      out_inc[p] = req_hs && (tgt_q == idx_t'(p));
      out_dec[p] = resp_hs && (grant == idx_t'(p));
    end
  end

  always_comb begin
    disp_resp_o                = '0;
    disp_resp_o.req_ready      = (state_q == EMPTY);
    disp_resp_o.resp_valid     = gnt_valid;
    disp_resp_o.result         = acc_resp_i[grant].result;
    disp_resp_o.trans_id       = acc_resp_i[grant].trans_id;
    disp_resp_o.exception      = acc_resp_i[grant].exception;
    disp_resp_o.load_complete  = |ld_dr;
    disp_resp_o.store_complete = |st_dr;
    busy_o                     = (state_q == FULL);
    for (int unsigned p = 0; p < NrAcc; p++) begin
      disp_resp_o.store_pending = disp_resp_o.store_pending | acc_resp_i[p].store_pending
                                  | (scnt_q[p] != '0);
      busy_o = busy_o | (outst_q[p] != '0) | (lcnt_q[p] != '0) | (scnt_q[p] != '0);
      acc_req_o[p]               = req_q;
      acc_req_o[p].req_valid     = fwd_en && (tgt_q == idx_t'(p));
      acc_req_o[p].resp_ready    = out_dec[p];
      acc_req_o[p].store_pending = disp_req_i.store_pending;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      req_q   <= '0;
      tgt_q   <= '0;
      rr_q    <= '0;
`ifdef ACC_PORT_ARBITER_IN_ORDER_EN
      last_tgt_q <= '0;
`endif
      for (int unsigned p = 0; p < NrAcc; p++) begin
        outst_q[p] <= '0;
        lcnt_q[p]  <= '0;
        scnt_q[p]  <= '0;
      end
    end else begin
      case (state_q)
        EMPTY: if (disp_req_i.req_valid) begin
          req_q   <= disp_req_i;
          tgt_q   <= decode_tgt(disp_req_i.insn[6:0]);
          state_q <= FULL;
        end
        FULL: if (req_hs) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
`ifdef ACC_PORT_ARBITER_IN_ORDER_EN
      if (req_hs) last_tgt_q <= tgt_q;
`endif
      if (resp_hs) rr_q <= idx_t'((32'(grant) + 32'd1) % NrAcc);
      for (int unsigned p = 0; p < NrAcc; p++) begin
        if (out_inc[p] && !out_dec[p]) outst_q[p] <= outst_q[p] + OW'(1);
        else if (out_dec[p] && !out_inc[p]) outst_q[p] <= outst_q[p] - OW'(1);
        if (acc_resp_i[p].load_complete && !ld_dr[p]) lcnt_q[p] <= lcnt_q[p] + CW'(1);
        else if (!acc_resp_i[p].load_complete && ld_dr[p]) lcnt_q[p] <= lcnt_q[p] - CW'(1);
        if (acc_resp_i[p].store_complete && !st_dr[p]) scnt_q[p] <= scnt_q[p] + CW'(1);
        else if (!acc_resp_i[p].store_complete && st_dr[p]) scnt_q[p] <= scnt_q[p] - CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NrAcc; g++) begin : g_ovf
    a_ld_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(acc_resp_i[g].load_complete && lcnt_q[g] == CW'(MaxCompl)));
    a_st_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(acc_resp_i[g].store_complete && scnt_q[g] == CW'(MaxCompl)));
  end

endmodule
